decode_stage: RTL and testbench

- Decode stage of the 5-stage in-order RV32I pipeline (fetch → decode → execute → memory → writeback).
- Holds the 32x32 register file. Decodes the instruction and generates the immediate and control signals.
- Resolves branches and jumps in decode and emits the redirect target.
- Registers all execute-stage operands and controls in the D→E pipeline register.

---
 rtl/decode_stage.sv | 196 +++++++++++++++++++
 tb/tb_decode_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: register file, instruction decode, branch/jump resolution
// and the D->E pipeline register feeding execute.
module decode_stage #(
  parameter int WORD     = 32,
  parameter int REG_SIZE = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [WORD-1:0]     pcD,
  input  logic [WORD-1:0]     instrD,
  input  logic                validD,
  input  logic                regWriteW,
  input  logic [REG_SIZE-1:0] writeRegW,
  input  logic [WORD-1:0]     resultW,
  input  logic [WORD-1:0]     ALUResultM,
  input  logic                validM,
  input  logic                validW,
  input  logic [1:0]          forward1,
  input  logic [1:0]          forward2,
  output logic                controllchangeD,
  output logic [WORD-1:0]     pcnD,
  output logic [REG_SIZE-1:0] raddr1D,
  output logic [REG_SIZE-1:0] raddr2D,
  output logic [REG_SIZE-1:0] raddr1E,
  output logic [REG_SIZE-1:0] raddr2E,
  output logic [REG_SIZE-1:0] writeRegE,
  output logic [WORD-1:0]     rdata1E,
  output logic [WORD-1:0]     rdata2E,
  output logic [WORD-1:0]     immE,
  output logic [WORD-1:0]     pcE,
  output logic [3:0]          ALUControlE,
  output logic [1:0]          ALUSrcE,
  output logic                regWriteE,
  output logic                memWriteE,
  output logic                mem2regE,
  output logic                finishE,
  output logic                validE
);

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011,
                         OP_SYSTEM = 7'b1110011;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_PASSB = 4'd10;

  typedef struct packed {
    logic [REG_SIZE-1:0] raddr1, raddr2, write_reg;
    logic [WORD-1:0]     rdata1, rdata2, imm, pc;
    logic [3:0]          alu_control;
    logic [1:0]          alu_src;
    logic                reg_write, mem_write, mem2reg, finish, valid;
  } de_t;

  de_t de_d, de_q;

  logic [WORD-1:0] rf_mem [0:(1<<REG_SIZE)-1];

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [WORD-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic use_rs1, use_rs2, is_branch, is_jal, is_jalr;
  logic reg_write, mem_write, mem2reg, finish;
  logic [3:0] alu_control, alu_func;
  logic [1:0] alu_src;
  logic [WORD-1:0] imm_sel, rdata1, rdata2, op_a, op_b;
  logic [REG_SIZE-1:0] rd_sel;
  logic taken;

  assign opcode = instrD[6:0];
  assign funct3 = instrD[14:12];
  assign imm_i  = {{(WORD-12){instrD[31]}}, instrD[31:20]};
  assign imm_s  = {{(WORD-12){instrD[31]}}, instrD[31:25], instrD[11:7]};
  assign imm_b  = {{(WORD-13){instrD[31]}}, instrD[31], instrD[7], instrD[30:25], instrD[11:8], 1'b0};
  assign imm_u  = {instrD[31:12], 12'b0};
  assign imm_j  = {{(WORD-21){instrD[31]}}, instrD[31], instrD[19:12], instrD[20], instrD[30:21], 1'b0};

  // Shared funct3 -> ALU op; instr[30] selects SUB (R-type only) and SRA.
  always_comb begin
    alu_func = ALU_ADD;
    case (funct3)
      3'b000: alu_func = (opcode == OP_R && instrD[30]) ? ALU_SUB : ALU_ADD;
      3'b001: alu_func = ALU_SLL;
      3'b010: alu_func = ALU_SLT;
      3'b011: alu_func = ALU_SLTU;
      3'b100: alu_func = ALU_XOR;
      3'b101: alu_func = instrD[30] ? ALU_SRA : ALU_SRL;
      3'b110: alu_func = ALU_OR;
      default: alu_func = ALU_AND;
    endcase
  end

  always_comb begin
    use_rs1 = 1'b0; use_rs2 = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    reg_write = 1'b0; mem_write = 1'b0; mem2reg = 1'b0; finish = 1'b0;
    alu_control = ALU_ADD; alu_src = 2'b00; imm_sel = '0;
    case (opcode)
      OP_R:      begin use_rs1 = 1'b1; use_rs2 = 1'b1; reg_write = 1'b1; alu_control = alu_func; end
      OP_I:      begin use_rs1 = 1'b1; reg_write = 1'b1; alu_control = alu_func; alu_src = 2'b01; imm_sel = imm_i; end
      OP_LOAD:   begin use_rs1 = 1'b1; reg_write = 1'b1; mem2reg = 1'b1; alu_src = 2'b01; imm_sel = imm_i; end
      OP_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; mem_write = 1'b1; alu_src = 2'b01; imm_sel = imm_s; end
      OP_LUI:    begin reg_write = 1'b1; alu_control = ALU_PASSB; alu_src = 2'b01; imm_sel = imm_u; end
      OP_AUIPC:  begin reg_write = 1'b1; alu_src = 2'b11; imm_sel = imm_u; end
      OP_JAL:    begin is_jal = 1'b1; reg_write = 1'b1; alu_src = 2'b11; imm_sel = WORD'(4); end
      OP_JALR:   begin use_rs1 = 1'b1; is_jalr = 1'b1; reg_write = 1'b1; alu_src = 2'b11; imm_sel = WORD'(4); end
      OP_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_branch = 1'b1; end
      OP_SYSTEM: finish = (instrD[31:7] == '0);
      default:   ;
    endcase
  end

  assign raddr1D = use_rs1 ? instrD[19:15] : '0;
  assign raddr2D = use_rs2 ? instrD[24:20] : '0;
  assign rd_sel  = reg_write ? instrD[11:7] : '0;

  // Reads see the same-cycle writeback so no extra bubble is needed.
  always_comb begin
    rdata1 = rf_mem[raddr1D];
    rdata2 = rf_mem[raddr2D];
    if (regWriteW && writeRegW == raddr1D) rdata1 = resultW;
    if (regWriteW && writeRegW == raddr2D) rdata2 = resultW;
    if (raddr1D == '0) rdata1 = '0;
    if (raddr2D == '0) rdata2 = '0;
  end

  always_ff @(posedge clk) begin
    if (regWriteW && writeRegW != '0) rf_mem[writeRegW] <= resultW;
  end

  always_comb begin
    op_a = rdata1;
    op_b = rdata2;
    if (forward1 == 2'b01 && validW) op_a = resultW;
    if (forward1 == 2'b10 && validM) op_a = ALUResultM;
    if (forward2 == 2'b01 && validW) op_b = resultW;
    if (forward2 == 2'b10 && validM) op_b = ALUResultM;
    case (funct3)
      3'b000:  taken = (op_a == op_b);
      3'b001:  taken = (op_a != op_b);
      3'b100:  taken = ($signed(op_a) < $signed(op_b));
      3'b101:  taken = ($signed(op_a) >= $signed(op_b));
      3'b110:  taken = (op_a < op_b);
      3'b111:  taken = (op_a >= op_b);
      default: taken = 1'b0;
    endcase
    pcnD = pcD + WORD'(4);
    if (is_branch) pcnD = pcD + imm_b;
    if (is_jal)    pcnD = pcD + imm_j;
    if (is_jalr)   pcnD = (op_a + imm_i) & ~WORD'(1);
  end

  assign controllchangeD = validD & ((is_branch & taken) | is_jal | is_jalr);

  always_comb begin
    de_d = de_q;
    if (en) begin
      de_d.raddr1      = raddr1D;
      de_d.raddr2      = raddr2D;
      de_d.rdata1      = rdata1;
      de_d.rdata2      = rdata2;
      de_d.pc          = pcD;
      de_d.valid       = validD;
      de_d.write_reg   = validD ? rd_sel      : '0;
      de_d.imm         = validD ? imm_sel     : '0;
      de_d.alu_control = validD ? alu_control : '0;
      de_d.alu_src     = validD ? alu_src     : '0;
      de_d.reg_write   = validD & reg_write;
      de_d.mem_write   = validD & mem_write;
      de_d.mem2reg     = validD & mem2reg;
      de_d.finish      = validD & finish;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) de_q <= '0;
    else        de_q <= de_d;
  end

  assign raddr1E     = de_q.raddr1;
  assign raddr2E     = de_q.raddr2;
  assign writeRegE   = de_q.write_reg;
  assign rdata1E     = de_q.rdata1;
  assign rdata2E     = de_q.rdata2;
  assign immE        = de_q.imm;
  assign pcE         = de_q.pc;
  assign ALUControlE = de_q.alu_control;
  assign ALUSrcE     = de_q.alu_src;
  assign regWriteE   = de_q.reg_write;
  assign memWriteE   = de_q.mem_write;
  assign mem2regE    = de_q.mem2reg;
  assign finishE     = de_q.finish;
  assign validE      = de_q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-encoded RV32I instructions with
// hand-computed decode, branch and pipeline-register expectations.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset, en, validD, regWriteW, validM, validW;
  logic [31:0] pcD, instrD, resultW, ALUResultM;
  logic [4:0]  writeRegW;
  logic [1:0]  forward1, forward2;
  logic        controllchangeD;
  logic [31:0] pcnD;
  logic [4:0]  raddr1D, raddr2D, raddr1E, raddr2E, writeRegE;
  logic [31:0] rdata1E, rdata2E, immE, pcE;
  logic [3:0]  ALUControlE;
  logic [1:0]  ALUSrcE;
  logic        regWriteE, memWriteE, mem2regE, finishE, validE;

  int checks = 0;
  int errors = 0;

  decode_stage #(.WORD(32), .REG_SIZE(5)) dut (
    .clk(clk), .reset(reset), .en(en), .pcD(pcD), .instrD(instrD), .validD(validD),
    .regWriteW(regWriteW), .writeRegW(writeRegW), .resultW(resultW),
    .ALUResultM(ALUResultM), .validM(validM), .validW(validW),
    .forward1(forward1), .forward2(forward2),
    .controllchangeD(controllchangeD), .pcnD(pcnD),
    .raddr1D(raddr1D), .raddr2D(raddr2D), .raddr1E(raddr1E), .raddr2E(raddr2E),
    .writeRegE(writeRegE), .rdata1E(rdata1E), .rdata2E(rdata2E), .immE(immE), .pcE(pcE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .regWriteE(regWriteE),
    .memWriteE(memWriteE), .mem2regE(mem2regE), .finishE(finishE), .validE(validE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    validD = 1'b0; regWriteW = 1'b1; writeRegW = a; resultW = d;
    tick();
    regWriteW = 1'b0;
  endtask

  localparam logic [31:0] I_ADDI  = 32'h00128313; // addi x6,x5,1
  localparam logic [31:0] I_ADD   = 32'h000000B3; // add  x1,x0,x0
  localparam logic [31:0] I_BEQ   = 32'h00208863; // beq  x1,x2,+16
  localparam logic [31:0] I_BLT   = 32'h0020C863; // blt  x1,x2,+16
  localparam logic [31:0] I_BGE   = 32'h0020D863; // bge  x1,x2,+16
  localparam logic [31:0] I_BNE   = 32'hFE209EE3; // bne  x1,x2,-4
  localparam logic [31:0] I_JAL   = 32'h008000EF; // jal  x1,+8
  localparam logic [31:0] I_JALR  = 32'h008180E7; // jalr x1,8(x3)
  localparam logic [31:0] I_LUI   = 32'hABCDE3B7; // lui  x7,0xABCDE
  localparam logic [31:0] I_SW    = 32'h0020A223; // sw   x2,4(x1)
  localparam logic [31:0] I_ECALL = 32'h00000073;

  initial begin
    reset = 1'b0; en = 1'b1; validD = 1'b1; regWriteW = 1'b0; validM = 1'b0; validW = 1'b0;
    pcD = 32'h40; instrD = I_ADDI; resultW = '0; ALUResultM = '0; writeRegW = '0;
    forward1 = 2'b00; forward2 = 2'b00;
    tick(); tick();
    check("reset_validE", {31'b0, validE}, 32'd0);
    check("reset_regWriteE", {31'b0, regWriteE}, 32'd0);
    reset = 1'b1;

    // Write-then-read with same-cycle bypass
    instrD = I_ADDI; validD = 1'b1; pcD = 32'h44;
    regWriteW = 1'b1; writeRegW = 5'd5; resultW = 32'h1234;
    #1;
    check("addi_raddr2D", {27'b0, raddr2D}, 32'd0);
    tick();
    regWriteW = 1'b0;
    check("addi_rdata1E", rdata1E, 32'h1234);
    check("addi_immE", immE, 32'd1);
    check("addi_alu", {28'b0, ALUControlE}, 32'd0);
    check("addi_src", {30'b0, ALUSrcE}, 32'd1);
    check("addi_rd", {27'b0, writeRegE}, 32'd6);
    check("addi_regWriteE", {31'b0, regWriteE}, 32'd1);
    check("addi_pcE", pcE, 32'h44);

    // Asynchronous reset mid-cycle, then normal load on release
    #2 reset = 1'b0;
    #1;
    check("async_rst_validE", {31'b0, validE}, 32'd0);
    check("async_rst_rd", {27'b0, writeRegE}, 32'd0);
    check("async_rst_rdata1E", rdata1E, 32'd0);
    reset = 1'b1;
    tick();
    check("post_rst_validE", {31'b0, validE}, 32'd1);
    check("post_rst_rdata1E", rdata1E, 32'h1234);

    // Writes to x0 are dropped, also on the bypass path
    instrD = I_ADD; regWriteW = 1'b1; writeRegW = 5'd0; resultW = 32'hFFFF;
    tick();
    regWriteW = 1'b0;
    check("x0_bypass_rdata1E", rdata1E, 32'd0);
    check("x0_bypass_rdata2E", rdata2E, 32'd0);
    tick();
    check("x0_rdata1E", rdata1E, 32'd0);
    check("x0_alu_add", {28'b0, ALUControlE}, 32'd0);

    wr(5'd1, 32'd7); wr(5'd2, 32'd7); wr(5'd3, 32'h203);

    // Branch resolution
    validD = 1'b1; pcD = 32'h100; instrD = I_BEQ; #1;
    check("beq_eq_taken", {31'b0, controllchangeD}, 32'd1);
    check("beq_pcn", pcnD, 32'h110);
    check("beq_raddr1D", {27'b0, raddr1D}, 32'd1);
    check("beq_raddr2D", {27'b0, raddr2D}, 32'd2);
    tick();
    check("beq_regWriteE", {31'b0, regWriteE}, 32'd0);
    check("beq_validE", {31'b0, validE}, 32'd1);
    wr(5'd2, 32'd8);
    validD = 1'b1; instrD = I_BEQ; #1;
    check("beq_ne_not_taken", {31'b0, controllchangeD}, 32'd0);
    forward1 = 2'b10; ALUResultM = 32'd8; validM = 1'b1; #1;
    check("beq_fwdM_taken", {31'b0, controllchangeD}, 32'd1);
    validM = 1'b0; #1;
    check("beq_fwdM_invalid", {31'b0, controllchangeD}, 32'd0);
    forward1 = 2'b11; validM = 1'b1; #1;
    check("beq_fwd11_regfile", {31'b0, controllchangeD}, 32'd0);
    forward1 = 2'b00; validM = 1'b0;
    forward2 = 2'b01; resultW = 32'd7; validW = 1'b1; #1;
    check("beq_fwdW_taken", {31'b0, controllchangeD}, 32'd1);
    forward2 = 2'b00; validW = 1'b0;
    instrD = I_BLT; #1;
    check("blt_taken", {31'b0, controllchangeD}, 32'd1);
    instrD = I_BGE; #1;
    check("bge_not_taken", {31'b0, controllchangeD}, 32'd0);
    instrD = I_BNE; #1;
    check("bne_neg_taken", {31'b0, controllchangeD}, 32'd1);
    check("bne_neg_pcn", pcnD, 32'hFC);
    validD = 1'b0; #1;
    check("bne_invalid", {31'b0, controllchangeD}, 32'd0);

    // Jumps
    validD = 1'b1; pcD = 32'h300; instrD = I_JAL; #1;
    check("jal_change", {31'b0, controllchangeD}, 32'd1);
    check("jal_pcn", pcnD, 32'h308);
    instrD = I_JALR; #1;
    check("jalr_change", {31'b0, controllchangeD}, 32'd1);
    check("jalr_pcn", pcnD, 32'h20A);
    tick();
    check("jalr_immE", immE, 32'd4);
    check("jalr_src", {30'b0, ALUSrcE}, 32'd3);
    check("jalr_rd", {27'b0, writeRegE}, 32'd1);

    // LUI, SW, ECALL, hold
    instrD = I_LUI; #1;
    check("lui_raddr1D", {27'b0, raddr1D}, 32'd0);
    tick();
    check("lui_immE", immE, 32'hABCDE000);
    check("lui_alu", {28'b0, ALUControlE}, 32'd10);
    check("lui_rd", {27'b0, writeRegE}, 32'd7);
    instrD = I_SW; tick();
    check("sw_memWriteE", {31'b0, memWriteE}, 32'd1);
    check("sw_regWriteE", {31'b0, regWriteE}, 32'd0);
    check("sw_rdata2E", rdata2E, 32'd8);
    check("sw_immE", immE, 32'd4);
    instrD = I_ECALL; tick();
    check("ecall_finishE", {31'b0, finishE}, 32'd1);
    check("ecall_regWriteE", {31'b0, regWriteE}, 32'd0);
    en = 1'b0; instrD = I_ADDI; pcD = 32'h500; tick(); tick();
    check("hold_finishE", {31'b0, finishE}, 32'd1);
    check("hold_regWriteE", {31'b0, regWriteE}, 32'd0);
    check("hold_pcE", pcE, 32'h300);
    en = 1'b1; validD = 1'b0; tick();
    check("invalid_validE", {31'b0, validE}, 32'd0);
    check("invalid_regWriteE", {31'b0, regWriteE}, 32'd0);
    check("invalid_finishE", {31'b0, finishE}, 32'd0);
    validD = 1'b1; instrD = 32'hFFFFFFFF; tick();
    check("unknown_regWriteE", {31'b0, regWriteE}, 32'd0);
    check("unknown_validE", {31'b0, validE}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
